// File: rtl/proyect_top.sv
// rtl/proyect_top.sv - PS/2 keyboard driven gas/temperature alarm controller.
// Receives scan-code set 2 bytes, maps keys to temperature/gas state, and runs the alarm FSM.
module proyect_top #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int ALE_TH     = 5,
  parameter int PEL_TH     = 8
) (
  input  logic       CLK_G,
  input  logic       reset_G,
  input  logic       ps2data,
  input  logic       ps2clk,
  input  logic       Rx_en,
  output logic [3:0] Temps,
  output logic       RESETFSM,
  output logic       Gas,
  output logic       Alerta,
  output logic       Peligro
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    ALE_T  = 4'(ALE_TH);
  localparam logic [3:0]    PEL_T  = 4'(PEL_TH);

  typedef enum logic [1:0] {NORMAL, ALERTA, PELIGRO} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] f_cnt;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [10:0]   frame;
  logic          frame_ok;
  logic [TW-1:0] to_cnt;
  logic          strobe;
  logic [7:0]    rx_byte;
  logic          brk;
  logic          pel_cond, ale_cond;
  state_t        state, state_next;

  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered clock only flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      f_cnt      <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        f_cnt <= '0;
      end else if (f_cnt == F_LAST) begin
        clk_filt <= clk_s2;
        f_cnt    <= '0;
      end else begin
        f_cnt <= f_cnt + 1'b1;
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign frame    = {dat_s2, shift};
  assign frame_ok = ~frame[0] & (^frame[9:1]) & frame[10];

  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      bit_cnt <= '0;
      shift   <= '0;
      to_cnt  <= '0;
      strobe  <= 1'b0;
      rx_byte <= '0;
    end else begin
      strobe <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok && Rx_en) begin
            strobe  <= 1'b1;
            rx_byte <= frame[8:1];
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shift   <= {dat_s2, shift[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled keyboard must not leave a half frame to corrupt the next one.
        if (to_cnt == T_LAST) begin
          bit_cnt <= '0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      Temps    <= '0;
      Gas      <= 1'b0;
      RESETFSM <= 1'b0;
      brk      <= 1'b0;
    end else begin
      RESETFSM <= 1'b0;
      if (strobe) begin
        if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else if (rx_byte == 8'hE0) begin
          brk <= brk;
        end else if (brk) begin
          brk <= 1'b0;
        end else begin
          case (rx_byte)
            8'h45: Temps <= 4'd0;
            8'h16: Temps <= 4'd1;
            8'h1E: Temps <= 4'd2;
            8'h26: Temps <= 4'd3;
            8'h25: Temps <= 4'd4;
            8'h2E: Temps <= 4'd5;
            8'h36: Temps <= 4'd6;
            8'h3D: Temps <= 4'd7;
            8'h3E: Temps <= 4'd8;
            8'h46: Temps <= 4'd9;
            8'h34: Gas <= 1'b1;
            8'h31: Gas <= 1'b0;
            8'h2D: RESETFSM <= 1'b1;
            default: Temps <= Temps;
          endcase
        end
      end
    end
  end

  assign pel_cond = (Temps >= PEL_T) || (Gas && (Temps >= ALE_T));
  assign ale_cond = (Temps >= ALE_T) || Gas;

  always_comb begin
    state_next = state;
    case (state)
      NORMAL: begin
        if (RESETFSM)      state_next = NORMAL;
        else if (pel_cond) state_next = PELIGRO;
        else if (ale_cond) state_next = ALERTA;
      end
      ALERTA: begin
        if (RESETFSM)       state_next = NORMAL;
        else if (pel_cond)  state_next = PELIGRO;
        else if (!ale_cond) state_next = NORMAL;
      end
      PELIGRO: begin
        if (RESETFSM) state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge CLK_G) begin
    if (reset_G) state <= NORMAL;
    else         state <= state_next;
  end

  assign Alerta  = (state == ALERTA);
  assign Peligro = (state == PELIGRO);

endmodule

// File: tb/tb_proyect_top.sv
// tb/tb_proyect_top.sv - scoreboard bench for proyect_top.
// Expected output changes are queued in order; a monitor pops one per observed change.
module tb_proyect_top;

  logic       clk = 1'b0;
  logic       reset_G = 1'b1;
  logic       ps2data = 1'b1;
  logic       ps2clk = 1'b1;
  logic       Rx_en = 1'b1;
  logic [3:0] Temps;
  logic       RESETFSM, Gas, Alerta, Peligro;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] val;
    int         gap;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  proyect_top #(.FILTER_LEN(8), .TIMEOUT(400), .ALE_TH(5), .PEL_TH(8)) dut (
    .CLK_G(clk), .reset_G(reset_G), .ps2data(ps2data), .ps2clk(ps2clk), .Rx_en(Rx_en),
    .Temps(Temps), .RESETFSM(RESETFSM), .Gas(Gas), .Alerta(Alerta), .Peligro(Peligro)
  );

  always #5 clk = ~clk;

  wire [7:0] outv = {Temps, Gas, RESETFSM, Alerta, Peligro};

  function automatic logic [7:0] ev(input int t, input bit g, input bit r, input bit a, input bit p);
    return {4'(t), g, r, a, p};
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic expect_out(input logic [7:0] v, input int gap, input string name);
    exp_t e;
    e.val = v;
    e.gap = gap;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2data = fr[i];
      repeat (10) @(negedge clk);
      ps2clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mk(b, 1'b0, 1'b1), 11);
  endtask

  // Monitor: every change on the output vector must match the next queued expectation.
  initial begin
    logic [7:0] prev;
    int         cyc;
    exp_t       e;
    wait (mon_en);
    prev = outv;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (outv !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change: got %h, required no change from %h", outv, prev);
        end else begin
          e = exp_q.pop_front();
          if (outv !== e.val || (e.gap != 0 && cyc != e.gap)) begin
            failures++;
            $display("FAIL %s: got %h after %0d cycles, required %h after %0d cycles",
                     e.name, outv, cyc, e.val, e.gap);
          end
        end
        prev = outv;
        cyc = 0;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    failures++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int wait_cyc;
    repeat (10) @(negedge clk);
    checks++;
    if (outv !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got %h, required 00", outv);
    end
    reset_G = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    expect_out(ev(3, 0, 0, 0, 0), 0, "digit3");
    send(8'h26);

    expect_out(ev(6, 0, 0, 0, 0), 0, "digit6");
    expect_out(ev(6, 0, 0, 1, 0), 1, "alerta_on");
    send(8'h36);
    send(8'hF0);
    send(8'h36);
    send(8'hF0);
    send(8'h16);

    expect_out(ev(6, 1, 0, 1, 0), 0, "gas_on");
    expect_out(ev(6, 1, 0, 0, 1), 1, "peligro_on");
    send(8'h34);

    expect_out(ev(0, 1, 0, 0, 1), 0, "digit0_latched");
    send(8'h45);

    expect_out(ev(0, 1, 1, 0, 1), 0, "resetfsm_pulse");
    expect_out(ev(0, 1, 0, 0, 0), 1, "fsm_normal");
    expect_out(ev(0, 1, 0, 1, 0), 1, "fsm_realerta");
    send(8'h2D);

    Rx_en = 1'b0;
    send(8'h46);
    Rx_en = 1'b1;
    send_bits(mk(8'h46, 1'b1, 1'b1), 11);
    send_bits(mk(8'h46, 1'b0, 1'b0), 11);

    send_bits(mk(8'h46, 1'b0, 1'b1), 5);
    repeat (410) @(negedge clk);
    expect_out(ev(8, 1, 0, 1, 0), 0, "digit8_after_timeout");
    expect_out(ev(8, 1, 0, 0, 1), 1, "peligro_after_timeout");
    send(8'h3E);

    expect_out(ev(8, 0, 0, 0, 1), 0, "gas_off_latched");
    send(8'h31);

    send_bits(mk(8'h16, 1'b0, 1'b1), 6);
    expect_out(ev(0, 0, 0, 0, 0), 0, "reset_midframe");
    reset_G = 1'b1;
    repeat (3) @(negedge clk);
    reset_G = 1'b0;
    repeat (20) @(negedge clk);

    expect_out(ev(5, 0, 0, 0, 0), 0, "digit5_after_reset");
    expect_out(ev(5, 0, 0, 1, 0), 1, "alerta_at5");
    send(8'h2E);

    expect_out(ev(8, 0, 0, 1, 0), 0, "digit8");
    expect_out(ev(8, 0, 0, 0, 1), 1, "peligro_at8");
    send(8'h3E);

    expect_out(ev(8, 0, 1, 0, 1), 0, "resetfsm_pulse2");
    expect_out(ev(8, 0, 0, 0, 0), 1, "fsm_normal2");
    expect_out(ev(8, 0, 0, 0, 1), 1, "fsm_repeligro");
    send(8'h2D);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    repeat (100) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
